// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam int INSTR_BYTES = 4;
    localparam int OPC_W       = 3;
    localparam int REG_W       = 5;

    // Offset travels beside this struct because its width follows Ancho.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } id_fields_t;
endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, flush kills
// the valid bit, neither holds everything.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic [W-1:0]     d_pc,
    input  id_fields_t       d_fields,
    input  logic [W-1:0]     d_offset,
    output logic             valid,
    output logic [W-1:0]     q_pc,
    output id_fields_t       q_fields,
    output logic [W-1:0]     q_offset
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            q_pc     <= '0;
            q_fields <= '0;
            q_offset <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            q_pc     <= d_pc;
            q_fields <= d_fields;
            q_offset <= d_offset;
        end else if (flush) begin
            valid    <= 1'b0;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register and IDLE/RUN/HALT control feeding the IF/ID register
// from a combinational instruction memory.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int Ancho   = 32,
    parameter int NumInst = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             br_take,
    input  logic [Ancho-1:0] br_target,
    input  logic [2:0]       im_opcode,
    input  logic [4:0]       im_rs1,
    input  logic [4:0]       im_rs2,
    input  logic [4:0]       im_rd,
    input  logic [Ancho-1:0] im_offset,
    output logic [Ancho-1:0] pc,
    output logic             id_valid,
    output logic [Ancho-1:0] id_pc,
    output logic [2:0]       id_opcode,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic [4:0]       id_rd,
    output logic [Ancho-1:0] id_offset,
    output logic             halted
);
    localparam logic [Ancho-1:0] LAST_PC = Ancho'((NumInst - 1) * INSTR_BYTES);
    localparam logic [Ancho-1:0] STEP    = Ancho'(INSTR_BYTES);

    state_t           state, state_nxt;
    logic [Ancho-1:0] pc_nxt;
    logic [Ancho-1:0] tgt;
    logic             tgt_ok;
    logic             load, flush;
    id_fields_t       im_fields, id_fields;

    assign tgt       = {br_target[Ancho-1:2], 2'b00};
    assign tgt_ok    = (tgt <= LAST_PC);
    assign im_fields = '{opcode: im_opcode, rs1: im_rs1, rs2: im_rs2, rd: im_rd};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (br_take) begin
                    if (!tgt_ok) state_nxt = HALT;
                end else if (!stall && pc == LAST_PC) begin
                    state_nxt = HALT;
                end
            end
            HALT: if (br_take && tgt_ok) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range redirects flush but leave pc parked where it was.
    always_comb begin
        pc_nxt = pc;
        load   = 1'b0;
        flush  = 1'b0;
        halted = (state == HALT);
        case (state)
            RUN: begin
                if (br_take) begin
                    flush = 1'b1;
                    if (tgt_ok) pc_nxt = tgt;
                end else if (!stall) begin
                    load = 1'b1;
                    if (pc != LAST_PC) pc_nxt = pc + STEP;
                end
            end
            HALT: begin
                if (br_take) begin
                    flush = 1'b1;
                    if (tgt_ok) pc_nxt = tgt;
                end else if (!stall) begin
                    flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    if_id_reg #(.W(Ancho)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (flush),
        .d_pc     (pc),
        .d_fields (im_fields),
        .d_offset (im_offset),
        .valid    (id_valid),
        .q_pc     (id_pc),
        .q_fields (id_fields),
        .q_offset (id_offset)
    );

    assign id_opcode = id_fields.opcode;
    assign id_rs1    = id_fields.rs1;
    assign id_rs2    = id_fields.rs2;
    assign id_rd     = id_fields.rd;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, then random traffic against
// a rule-level model of the fetch stage.
module tb_pc_fetch_unit;
    localparam int A  = 32;
    localparam int NI = 7;
    localparam int LAST = (NI - 1) * 4;

    logic          clk = 1'b0;
    logic          rst, start, stall, br_take;
    logic [A-1:0]  br_target;
    logic [2:0]    im_opcode;
    logic [4:0]    im_rs1, im_rs2, im_rd;
    logic [A-1:0]  im_offset;
    logic [A-1:0]  pc, id_pc, id_offset;
    logic          id_valid, halted;
    logic [2:0]    id_opcode;
    logic [4:0]    id_rs1, id_rs2, id_rd;

    int total = 0;
    int bad   = 0;

    // Program image, indexed by word address.
    logic [49:0] mem [NI];

    always #5 clk = ~clk;

    pc_fetch_unit #(.Ancho(A), .NumInst(NI)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .br_take(br_take), .br_target(br_target),
        .im_opcode(im_opcode), .im_rs1(im_rs1), .im_rs2(im_rs2),
        .im_rd(im_rd), .im_offset(im_offset),
        .pc(pc), .id_valid(id_valid), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_offset(id_offset), .halted(halted)
    );

    function automatic logic [49:0] fetch(input logic [A-1:0] a);
        if (a[1:0] == 2'b00 && (a >> 2) < NI) return mem[a >> 2];
        return '0;
    endfunction

    always_comb begin
        {im_opcode, im_rs1, im_rs2, im_rd, im_offset} = fetch(pc);
    end

    // Reference model, in terms of "has started" / "is halted" flags.
    bit            m_started, m_halted, m_v;
    logic [A-1:0]  m_pc, m_idpc;
    logic [49:0]   m_f;

    task automatic model_step();
        logic [A-1:0] t;
        t = br_target & ~32'd3;
        if (rst) begin
            m_started = 0; m_halted = 0; m_v = 0;
            m_pc = 0; m_idpc = 0; m_f = '0;
        end else if (!m_started) begin
            if (start) m_started = 1;
        end else if (br_take) begin
            m_v = 0;
            if (t <= LAST) begin
                m_pc = t;
                m_halted = 0;
            end else begin
                m_halted = 1;
            end
        end else if (stall) begin
        end else if (m_halted) begin
            m_v = 0;
        end else begin
            m_idpc = m_pc;
            m_f    = fetch(m_pc);
            m_v    = 1;
            if (m_pc == LAST) m_halted = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [49:0] id_bus();
        return {id_opcode, id_rs1, id_rs2, id_rd, id_offset};
    endfunction

    typedef struct {
        bit           rst, start, stall, br;
        logic [A-1:0] tgt;
        logic [A-1:0] e_pc;
        bit           e_v;
        logic [A-1:0] e_idpc;
        bit           e_h;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(bit r, bit s, bit st, bit b, int tg, int p, bit vl, int ip, bit h);
        vec_t x;
        x.rst = r; x.start = s; x.stall = st; x.br = b; x.tgt = A'(tg);
        x.e_pc = A'(p); x.e_v = vl; x.e_idpc = A'(ip); x.e_h = h;
        return x;
    endfunction

    initial begin
        for (int i = 0; i < NI; i++)
            mem[i] = {$urandom, $urandom} & 50'h3_FFFF_FFFF_FFFF;

        //              rst st stl br tgt    pc   v idpc  h
        tbl.push_back(v(0, 1, 0, 0, 0,     0,   0, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     4,   1, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     8,   1, 4,    0));
        tbl.push_back(v(0, 0, 1, 0, 0,     8,   1, 4,    0));
        tbl.push_back(v(0, 0, 1, 0, 0,     8,   1, 4,    0));
        tbl.push_back(v(0, 0, 1, 0, 0,     8,   1, 4,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     12,  1, 8,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     16,  1, 12,   0));
        tbl.push_back(v(0, 0, 1, 1, 'h13,  16,  0, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     20,  1, 16,   0));
        tbl.push_back(v(0, 0, 0, 0, 0,     24,  1, 20,   0));
        tbl.push_back(v(0, 0, 0, 0, 0,     24,  1, 24,   1));
        tbl.push_back(v(0, 0, 0, 0, 0,     24,  0, 0,    1));
        tbl.push_back(v(0, 0, 0, 1, 4,     4,   0, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     8,   1, 4,    0));
        tbl.push_back(v(0, 1, 0, 0, 0,     12,  1, 8,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     16,  1, 12,   0));
        tbl.push_back(v(0, 0, 0, 0, 0,     20,  1, 16,   0));
        tbl.push_back(v(0, 0, 0, 0, 0,     24,  1, 20,   0));
        tbl.push_back(v(0, 0, 0, 0, 0,     24,  1, 24,   1));
        tbl.push_back(v(0, 0, 0, 1, 'h40,  24,  0, 0,    1));
        tbl.push_back(v(0, 1, 0, 0, 0,     24,  0, 0,    1));
        tbl.push_back(v(0, 0, 0, 1, 8,     8,   0, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     12,  1, 8,    0));
        tbl.push_back(v(1, 0, 1, 0, 0,     0,   0, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     0,   0, 0,    0));
        tbl.push_back(v(0, 0, 1, 1, 8,     0,   0, 0,    0));
        tbl.push_back(v(0, 1, 0, 0, 0,     0,   0, 0,    0));
        tbl.push_back(v(0, 0, 0, 0, 0,     4,   1, 0,    0));
        tbl.push_back(v(0, 0, 0, 1, 'h1C,  4,   0, 0,    1));

        start = 0; stall = 0; br_take = 0; br_target = '0;
        rst = 1;
        step();
        step();
        rst = 0;
        chk("reset_pc",     64'(pc), 0);
        chk("reset_valid",  64'(id_valid), 0);
        chk("reset_halted", 64'(halted), 0);
        chk("reset_idpc",   64'(id_pc), 0);
        chk("reset_fields", 64'(id_bus()), 0);
        step();
        chk("idle_pc",    64'(pc), 0);
        chk("idle_valid", 64'(id_valid), 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start; stall = tbl[i].stall;
            br_take = tbl[i].br; br_target = tbl[i].tgt;
            step();
            chk($sformatf("vec%0d_pc", i),     64'(pc), 64'(tbl[i].e_pc));
            chk($sformatf("vec%0d_valid", i),  64'(id_valid), 64'(tbl[i].e_v));
            chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(tbl[i].e_h));
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d_idpc", i),   64'(id_pc), 64'(tbl[i].e_idpc));
                chk($sformatf("vec%0d_fields", i), 64'(id_bus()), 64'(fetch(tbl[i].e_idpc)));
            end
        end

        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            start     = ($urandom_range(0, 7) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            br_take   = ($urandom_range(0, 9) == 0);
            br_target = A'($urandom_range(0, 'h3F));
            step();
            chk("rnd_pc",     64'(pc), 64'(m_pc));
            chk("rnd_valid",  64'(id_valid), 64'(m_v));
            chk("rnd_halted", 64'(halted), 64'(m_halted));
            if (m_v) begin
                chk("rnd_idpc",   64'(id_pc), 64'(m_idpc));
                chk("rnd_fields", 64'(id_bus()), 64'(m_f));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage: holds the program counter, drives it to the combinational instruction memory, and registers the decoded fields it returns (Opcode, Rs1, Rs2, Rd, Offset) into an IF/ID pipeline register for the decode/execute stage. Supports start-up, stall, taken-branch redirect with flush, and halt at the end of the program image. Sits between the control/branch logic (downstream) and the instruction memory (side), replacing the testbench-driven PC.

## Interface
- Ancho, 32, data/address width of PC and Offset
- NumInst, 7, instructions in the memory image; last valid PC = (NumInst-1)*4
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching from PC 0
- stall  in  1  hold PC and IF/ID contents
- br_take  in  1  redirect fetch (from downstream branch resolution)
- br_target  in  Ancho  redirect address; bits [1:0] ignored (treated as 0)
- im_opcode  in  3  Opcode from instruction memory
- im_rs1, im_rs2, im_rd  in  5 each  register fields from instruction memory
- im_offset  in  Ancho  Offset from instruction memory
- pc  out  Ancho  current fetch address, to instruction memory PC
- id_valid  out  1  IF/ID holds a live instruction
- id_pc  out  Ancho  PC of the IF/ID instruction
- id_opcode, id_rs1, id_rs2, id_rd, id_offset  out  3/5/5/5/Ancho  registered fields
- halted  out  1  fetch stopped at end of image (state HALT)

## Operation
- States: IDLE, RUN, HALT. Reset: state IDLE, pc=0, id_valid=0, all id_* fields 0, halted=0.
- IDLE: pc held at 0, id_valid=0; start=1 -> RUN. br_take and stall ignored.
- RUN, per cycle, priority br_take > stall > advance:
  - br_take: pc <= {br_target[Ancho-1:2],2'b00}; id_valid <= 0 (flush). Target > last PC -> HALT, pc unchanged; else stay RUN.
  - stall: pc and all id_* hold.
  - advance: IF/ID <= {pc, im_*}, id_valid <= 1; if pc == last PC -> HALT and pc holds, else pc <= pc+4 (mod 2^Ancho).
- HALT: halted=1, pc holds. stall holds IF/ID; otherwise id_valid <= 0 (last instruction drains). br_take with in-range target -> pc <= target, id_valid <= 0, RUN; out-of-range -> stays HALT, flush.
- start ignored outside IDLE. Only rst returns to IDLE.
- rst mid-operation overrides everything in the same edge.

## Timing
- Instruction memory is combinational: im_* reflect pc in the same cycle.
- Fetch latency 1: instruction at pc appears on id_* with id_valid=1 one edge after pc is presented (unstalled).
- start at edge N -> RUN after N; first id_valid=1 (id_pc=0) after edge N+1.
- Branch penalty: one bubble (id_valid=0) the cycle after br_take; target instruction on id_* one edge later.
- Throughput: one instruction per cycle while not stalled.
- halted rises the edge the last instruction is captured; id_valid falls one edge later unless stalled.

## Structure
- Package fetch_pkg: state enum {IDLE, RUN, HALT}, INSTR_BYTES=4, OPC_W=3, REG_W=5, packed struct for IF/ID fields.
- Sub-module if_id_reg: clocked register with load, flush, hold; pc_fetch_unit owns FSM and PC logic.

## Test plan
- Reset: assert rst 2 cycles -> pc=0, id_valid=0, halted=0, all id_* =0; state IDLE while start=0.
- Straight line, NumInst=7: start pulse -> id_pc 0,4,...,24 on consecutive cycles with matching im_* fields; halted=1 on capture of 24; id_valid=0 next cycle; pc stays 24.
- Stall: assert stall 3 cycles at pc=8 -> pc and id_* (id_pc=4) frozen 3 cycles, then resume with id_pc=8.
- Branch: br_take with br_target=0x13 at pc=16, stall=1 same cycle -> pc=0x10 next (bits masked, branch wins), one bubble, then id_pc=0x10.
- Halt/resume: in HALT, br_take to 4 -> RUN, fetch resumes from 4; br_take to 0x40 -> remains HALT, id_valid=0.
- Reset mid-run at pc=12 with stall=1 -> next cycle pc=0, id_valid=0, IDLE; start ignored in RUN/HALT.
